// File: rtl/shift_8_bit.sv
// ---------------------------------------------------------------------------
// shift_8_bit
//   Registered one-position bidirectional shifter for the ALU datapath.
//   The operand is treated as a 10-bit word {shift_in_left, D, shift_in_right}
//   that is shifted logically by one place. The ends of the shifted word land
//   in the two bit buckets, and the middle eight bits become S.
//
// Ports
//   clk            in   1  clock, rising edge
//   reset          in   1  synchronous, active-high; clears all outputs
//   D              in   8  data to shift
//   shift_in_right in   1  fill bit entering S[0] on a left shift
//   shift_in_left  in   1  fill bit entering S[7] on a right shift
//   select         in   1  0 = shift left, 1 = shift right
//   S              out  8  shifted result (registered)
//   bb_right       out  1  bit shifted out of the right end (registered)
//   bb_left        out  1  bit shifted out of the left end (registered)
// ---------------------------------------------------------------------------
module shift_8_bit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] D,
  input  logic       shift_in_right,
  input  logic       shift_in_left,
  input  logic       select,
  output logic [7:0] S,
  output logic       bb_right,
  output logic       bb_left
);

  logic [9:0] w_word;
  logic [9:0] w_shifted;
  logic [9:0] w_word_left;
  logic [9:0] w_word_right;
  logic [9:0] r_result;

  assign w_word = {shift_in_left, D, shift_in_right};

  // A left shift pushes shift_in_left off the top of the 10-bit word and
  // zero-fills the bottom, so bb_right is 0 and shift_in_left is ignored.
  // A right shift is the mirror image. The unused bucket is therefore always
  // driven to 0 by the zero fill, never held.
  assign w_word_left  = {w_word[8:0], 1'b0};
  assign w_word_right = {1'b0, w_word[9:1]};

  always_comb begin
    w_shifted = w_word_left;
    if (select) begin
      w_shifted = w_word_right;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= 10'd0;
    end else begin
      r_result <= w_shifted;
    end
  end

  assign bb_left  = r_result[9];
  assign S        = r_result[8:1];
  assign bb_right = r_result[0];

endmodule

// File: tb/tb_shift_8_bit.sv
module tb_shift_8_bit;

  logic       clk;
  logic       reset;
  logic [7:0] D;
  logic       shift_in_right;
  logic       shift_in_left;
  logic       select;
  logic [7:0] S;
  logic       bb_right;
  logic       bb_left;

  int n_checks;
  int n_fail;

  shift_8_bit dut (
    .clk            (clk),
    .reset          (reset),
    .D              (D),
    .shift_in_right (shift_in_right),
    .shift_in_left  (shift_in_left),
    .select         (select),
    .S              (S),
    .bb_right       (bb_right),
    .bb_left        (bb_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: 10-bit logical shift of X = {shift_in_left, D, shift_in_right}
  // written as plain arithmetic.
  function automatic int model(input int x, input bit sel);
    if (sel) return x / 2;
    return (x * 2) % 1024;
  endfunction

  // Drive one set of inputs, take one rising edge, sample 1 time unit later.
  task automatic apply(input bit rst, input int x, input bit sel);
    logic [9:0] xv;
    xv             = x[9:0];
    reset          = rst;
    shift_in_left  = xv[9];
    D              = xv[8:1];
    shift_in_right = xv[0];
    select         = sel;
    @(posedge clk);
    #1;
  endtask

  function automatic int observed();
    return int'({bb_left, S, bb_right});
  endfunction

  initial begin
    int order [$];
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; D = 8'h00; shift_in_right = 1'b0; shift_in_left = 1'b0; select = 1'b0;
    @(negedge clk);

    // Reset overrides a data pattern that would otherwise produce nonzero output.
    reset = 1'b1; D = 8'hFF; select = 1'b0; shift_in_right = 1'b1; shift_in_left = 1'b1;
    @(posedge clk); #1;
    check("reset_S",  S, 8'h00);
    check("reset_bbl", bb_left, 1'b0);
    check("reset_bbr", bb_right, 1'b0);

    // First result after reset release.
    reset = 1'b0; D = 8'h81; shift_in_right = 1'b1; shift_in_left = 1'b0; select = 1'b0;
    @(posedge clk); #1;
    check("left81_S",   S, 8'h03);
    check("left81_bbl", bb_left, 1'b1);
    check("left81_bbr", bb_right, 1'b0);

    // Output holds between edges.
    @(negedge clk);
    check("hold_S", S, 8'h03);

    // Right shift with fill.
    D = 8'h81; shift_in_left = 1'b1; shift_in_right = 1'b0; select = 1'b1;
    @(posedge clk); #1;
    check("right81_S",   S, 8'hC0);
    check("right81_bbr", bb_right, 1'b1);
    check("right81_bbl", bb_left, 1'b0);

    // shift_in_left is ignored on a left shift.
    D = 8'h55; shift_in_left = 1'b1; shift_in_right = 1'b0; select = 1'b0;
    @(posedge clk); #1;
    check("ign_S",   S, 8'hAA);
    check("ign_bbl", bb_left, 1'b0);
    check("ign_bbr", bb_right, 1'b0);

    // Back-to-back alternation with D=A5, fills 0.
    for (int i = 0; i < 8; i++) begin
      D = 8'hA5; shift_in_left = 1'b0; shift_in_right = 1'b0; select = i[0];
      @(posedge clk); #1;
      if (i[0] == 1'b0) begin
        check("alt_left", observed(), {1'b1, 8'h4A, 1'b0});
      end else begin
        check("alt_right", observed(), {1'b0, 8'h52, 1'b1});
      end
    end

    // Exhaustive sweep of X and select, with a one-cycle reset mid-stream.
    for (int x = 0; x < 1024; x++) begin
      for (int s = 0; s < 2; s++) begin
        if (x == 517 && s == 1) begin
          apply(1'b1, x, 1'b0);
          check("mid_reset", observed(), 0);
        end
        apply(1'b0, x, s[0]);
        check(s == 0 ? "sweep_left" : "sweep_right", observed(), model(x, s[0]));
      end
    end

    // Randomized stream: random operands, select and occasional reset.
    for (int i = 0; i < 600; i++) begin
      int  x;
      bit  sel;
      bit  rst;
      x   = int'($urandom_range(0, 1023));
      sel = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 19) == 0);
      apply(rst, x, sel);
      if (rst) check("rand_reset", observed(), 0);
      else     check("rand_shift", observed(), model(x, sel));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_8_bit.md
Name: shift_8_bit

Overview:
- 8-bit, one-position, bidirectional shifter for the ALU datapath.
- Has a serial fill bit at each end and a "bit bucket" output at each end that captures the bit shifted out.
- Outputs are registered on a single clock with synchronous active-high reset.
- View the operation as a 10-bit word {shift_in_left, D, shift_in_right} shifted by one position.

Parameters:
- None. Width is fixed at 8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- S  output  8  shifted data result (registered).
- bb_right  output  1  bit shifted out of the right end (registered).
- bb_left  output  1  bit shifted out of the left end (registered).
- D  input  8  data to shift.
- shift_in_right  input  1  fill bit entering at S[0] on a left shift.
- shift_in_left  input  1  fill bit entering at S[7] on a right shift.
- select  input  1  0 = shift left, 1 = shift right.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a rising clk edge with reset=1, S=8'h00, bb_left=0 and bb_right=0. Reset overrides all other inputs.
- Latency: inputs are sampled on each rising edge with reset=0. The result is visible one cycle later and held until the next edge. There is no handshake and no enable: a new result is produced every cycle, so throughput is one per clock.
- Left shift (select=0):
  - S <= {D[6:0], shift_in_right}
  - bb_left <= D[7]
  - bb_right <= 0
  - Equivalently, {bb_left, S, bb_right} = {D, shift_in_right, 0}. shift_in_left is ignored.
- Right shift (select=1):
  - S <= {shift_in_left, D[7:1]}
  - bb_right <= D[0]
  - bb_left <= 0
  - Equivalently, {bb_left, S, bb_right} = {0, shift_in_left, D}. shift_in_right is ignored.
- Combined view: the 10-bit output {bb_left, S, bb_right} equals X<<1 when select=0 and X>>1 when select=1, where X = {shift_in_left, D, shift_in_right}. Both shifts are logical, 10 bits wide, with zero fill and no wrap-around.
- Unused bucket: the bucket on the side that does not receive a shifted-out bit is always driven to 0, never held at its old value.
- Reset mid-operation: the pending result is discarded and outputs are 0 after that edge. Normal operation resumes on the first edge with reset=0.
- Select changing every cycle: each cycle's result depends only on that cycle's sampled inputs. No history, no multi-cycle state.
- X/Z on inputs: not supported; behaviour is unspecified.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: drive D=8'hFF, select=0, reset=1 for one edge -> S=8'h00, bb_left=0, bb_right=0. Then release reset and apply D=8'h81, shift_in_right=1, select=0 -> next cycle S=8'h03, bb_left=1, bb_right=0.
- Right shift: D=8'h81, shift_in_left=1, shift_in_right=0, select=1 -> S=8'hC0, bb_right=1, bb_left=0.
- Ignored fill bit: D=8'h55, shift_in_left=1, shift_in_right=0, select=0 -> S=8'hAA, bb_left=0, bb_right=0. shift_in_left has no effect.
- Exhaustive: for X = 0..1023 and select in {0,1}, apply one set of inputs per cycle. Compare {bb_left, S, bb_right} one cycle later against X<<1 / X>>1 truncated to 10 bits -> 2048 matches, 0 mismatches.
- Back-to-back alternation: alternate select=0/1 every cycle with D=8'hA5 and both fill bits 0 -> outputs alternate between {S=8'h4A, bb_left=1, bb_right=0} and {S=8'h52, bb_left=0, bb_right=1} with exactly one-cycle latency.
- Mid-stream reset: assert reset for one cycle during the exhaustive sweep -> outputs are 0 on that cycle. Correct results resume on the following cycle.
